bus8088_master: RTL and testbench

Synthesizable bus initiator that generates Intel 8088 minimum-mode bus cycles (T1–T4 with READY-driven wait states) from a simple request/response handshake. It drives the multiplexed AD bus, the upper address bits and the bus control strobes. It is the initiator counterpart to the existing ALE/RD/WR-decoding memory and I/O responders (FSM + datapath), so those responders can be exercised without the behavioural CPU model. It sits where the processor sits: in front of the 8282 address latch and the 8286 transceiver.

---
 rtl/bus8088_pkg.sv | 44 ++++
 rtl/bus8088_master.sv | 202 ++++++++++++++++++++
 tb/tb_bus8088_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus8088_pkg.sv
// Shared definitions for the 8088 min-mode bus initiator and its responder benches.
// State encoding, default I/O address width and strobe idle levels.
package bus8088_pkg;

  typedef enum logic [2:0] {
    TI,
    T1,
    T2,
    T3,
    TW,
    T4,
    TH
  } bus_state_e;

  localparam int IO_AW_DEF = 16;

  localparam logic ALE_IDLE = 1'b0;
  localparam logic RD_IDLE  = 1'b1;
  localparam logic WR_IDLE  = 1'b1;
  localparam logic DEN_IDLE = 1'b1;
  localparam logic DTR_IDLE = 1'b1;
  localparam logic IOM_IDLE = 1'b0;

  // Upper address bits A[19:8]; I/O cycles clear everything at or above aw.
  function automatic logic [11:0] upper_addr(
    input logic [19:0] a,
    input logic        io,
    input int          aw
  );
    logic [11:0] r;
    r = a[19:8];
    for (int i = 0; i < 12; i++) begin
      if (io && ((i + 8) >= aw)) begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic data_phase(input bus_state_e s);
    return (s == T2) || (s == T3) || (s == TW);
  endfunction

endpackage

// File: rtl/bus8088_master.sv
// 8088 minimum-mode bus initiator: T1-T4 cycles with READY wait states.
// Define BUS8088_HOLD_EN to honour HOLD/HLDA; otherwise HOLD is ignored.
module bus8088_master
  import bus8088_pkg::*;
#(
  parameter int IO_AW     = IO_AW_DEF,
  parameter int INIT_WAIT = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  inout  wire  [7:0]  AD,
  output logic [11:0] A,
  output logic        IOM,
  output logic        ALE,
  output logic        RD,
  output logic        WR,
  output logic        DTR,
  output logic        DEN,
  input  logic        READY,
  input  logic        HOLD,
  output logic        HLDA
);

`ifdef BUS8088_HOLD_EN
  localparam logic HOLD_EN = 1'b1;
`else
  localparam logic HOLD_EN = 1'b0;
`endif

  localparam logic [1:0] WAIT_INIT = 2'(INIT_WAIT);

  bus_state_e  state_q, state_d;
  logic [19:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        io_q, io_d;
  logic [1:0]  wcnt_q, wcnt_d;
  logic [7:0]  rdata_q, rdata_d;

  logic        ale_q, ale_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic        den_q, den_d;
  logic        dtr_q, dtr_d;
  logic        iom_q, iom_d;
  logic [11:0] a_q, a_d;
  logic        oe_q, oe_d;
  logic [7:0]  ado_q, ado_d;
  logic        rsp_q, rsp_d;
  logic        hlda_q, hlda_d;

  logic        hold_req;
  logic        accept;
  logic        idle_ph;
  logic        dph;
  logic        t1_next;

  assign hold_req  = HOLD_EN & HOLD;
  assign idle_ph   = (state_q == TI) || (state_q == T4);
  assign req_ready = !RESET && !hold_req && idle_ph;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    io_d    = io_q;
    wcnt_d  = wcnt_q;
    rdata_d = rdata_q;

    if (accept) begin
      addr_d  = req_addr;
      wdata_d = req_wdata;
      write_d = req_write;
      io_d    = req_io;
      wcnt_d  = WAIT_INIT;
    end

    unique case (state_q)
      TI, T4: begin
        if (hold_req) begin
          state_d = TH;
        end else if (accept) begin
          state_d = T1;
        end else begin
          state_d = TI;
        end
      end
      T1: state_d = T2;
      T2: state_d = T3;
      T3, TW: begin
        // Forced waits are burnt before READY is looked at.
        if (wcnt_q != 2'd0) begin
          wcnt_d  = wcnt_q - 2'd1;
          state_d = TW;
        end else if (!READY) begin
          state_d = TW;
        end else begin
          state_d = T4;
        end
      end
      TH: begin
        if (!hold_req) begin
          state_d = TI;
        end
      end
      default: state_d = TI;
    endcase

    if ((state_q == T3 || state_q == TW) &&
        (state_d == T4) && !write_q) begin
      rdata_d = AD;
    end
  end

  // Outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    t1_next = (state_d == T1);
    dph     = data_phase(state_d);
    ale_d   = t1_next;
    rd_d    = !(dph && !write_d);
    wr_d    = !(dph && write_d);
    den_d   = !dph;
    dtr_d   = t1_next ? write_d : dtr_q;
    iom_d   = t1_next ? io_d : iom_q;
    a_d     = t1_next ? upper_addr(addr_d, io_d, IO_AW) : a_q;
    oe_d    = t1_next || (dph && write_d);
    ado_d   = t1_next ? addr_d[7:0] : wdata_d;
    rsp_d   = (state_d == T4);
    hlda_d  = HOLD_EN && (state_d == TH);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= TI;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      io_q    <= 1'b0;
      wcnt_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      io_q    <= io_d;
      wcnt_q  <= wcnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ale_q  <= ALE_IDLE;
      rd_q   <= RD_IDLE;
      wr_q   <= WR_IDLE;
      den_q  <= DEN_IDLE;
      dtr_q  <= DTR_IDLE;
      iom_q  <= IOM_IDLE;
      a_q    <= '0;
      oe_q   <= 1'b0;
      ado_q  <= '0;
      rsp_q  <= 1'b0;
      hlda_q <= 1'b0;
    end else begin
      ale_q  <= ale_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      den_q  <= den_d;
      dtr_q  <= dtr_d;
      iom_q  <= iom_d;
      a_q    <= a_d;
      oe_q   <= oe_d;
      ado_q  <= ado_d;
      rsp_q  <= rsp_d;
      hlda_q <= hlda_d;
    end
  end

  assign AD        = oe_q ? ado_q : 8'bz;
  assign A         = a_q;
  assign IOM       = iom_q;
  assign ALE       = ale_q;
  assign RD        = rd_q;
  assign WR        = wr_q;
  assign DTR       = dtr_q;
  assign DEN       = den_q;
  assign HLDA      = hlda_q;
  assign rsp_valid = rsp_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_bus8088_master.sv
// Scoreboard bench for bus8088_master with a behavioural memory/I-O responder.
// Exercises BUS8088_HOLD_EN behaviour when that macro is defined.
`timescale 1ns/1ps
module tb_bus8088_master;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_io = 1'b0;
  logic [19:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  wire  [7:0]  AD;
  logic [11:0] A;
  logic        IOM, ALE, RD, WR, DTR, DEN;
  logic        READY = 1'b1;
  logic        HOLD = 1'b0;
  logic        HLDA;

  bus8088_master dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_io(req_io),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .AD(AD), .A(A), .IOM(IOM), .ALE(ALE), .RD(RD), .WR(WR),
    .DTR(DTR), .DEN(DEN), .READY(READY), .HOLD(HOLD), .HLDA(HLDA)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: memory indexed by {a[19:16],a[7:0]}, I/O at FF00-FF0F.
  logic [7:0]  mem [0:4095];
  logic [7:0]  io_mem [0:15];
  logic [19:0] lat_addr = '0;
  logic        lat_io = 1'b0;
  logic [7:0]  tb_dq = '0;
  logic        probe = 1'b0;
  int          ale_prev = -100;
  int          ale_last = -100;

  function automatic logic [7:0] lookup(input logic [19:0] a, input logic io);
    if (io) return (a[15:4] == 12'hFF0) ? io_mem[a[3:0]] : 8'hFF;
    return mem[{a[19:16], a[7:0]}];
  endfunction

  always @(negedge CLK) begin
    if (ALE) begin
      lat_addr <= {A, AD};
      lat_io   <= IOM;
      tb_dq    <= lookup({A, AD}, IOM);
      ale_prev <= ale_last;
      ale_last <= cyc;
    end
  end

  always @(negedge CLK) begin
    if (!RESET && !WR) begin
      if (lat_io) begin
        if (lat_addr[15:4] == 12'hFF0) io_mem[lat_addr[3:0]] = AD;
      end else begin
        mem[{lat_addr[19:16], lat_addr[7:0]}] = AD;
      end
    end
  end

  // Junk while READY is low catches early read-data capture.
  assign AD = !RD ? (READY ? tb_dq : 8'hEE) : (probe ? 8'h5C : 8'bz);

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] last_rd = 8'h00;

  always @(negedge CLK) begin : mon
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_cycle", cyc, e.due);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(e.data));
      end
    end
  end

  task automatic issue(input logic wr, input logic io,
                       input logic [19:0] addr, input logic [7:0] wd,
                       input logic [7:0] exp_rd, input int waits,
                       output int acc);
    int n;
    @(negedge CLK);
    req_valid = 1'b1;
    req_write = wr;
    req_io    = io;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge CLK);
    #1;
    acc = cyc;
    req_valid = 1'b0;
    if (!wr) last_rd = exp_rd;
    sb.push_back('{last_rd, acc + 3 + waits});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a1, a2;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) io_mem[i] = 8'h00;
    mem[12'h012] = 8'hA5;
    mem[12'h040] = 8'h5A;
    io_mem[10]   = 8'h6B;

    repeat (2) @(negedge CLK);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_strobes", 32'({ALE, RD, WR, DEN, DTR, IOM}), 32'b011110);
    chk("rst_A", 32'(A), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_rdata, HLDA}), 32'd0);
    probe = 1'b1;
    #1 chk("rst_AD_float", 32'(AD), 32'h5C);
    probe = 1'b0;
    RESET = 1'b0;
    #1 chk("ready_after_rst", 32'(req_ready), 32'd1);

    // Memory read, zero waits
    issue(1'b0, 1'b0, 20'h00012, 8'h00, 8'hA5, 0, a1);
    @(negedge CLK);
    chk("rd_t1_ale", 32'(ALE), 32'd1);
    chk("rd_t1_ad", 32'(AD), 32'h12);
    chk("rd_t1_a", 32'(A), 32'h000);
    chk("rd_t1_iom_dtr", 32'({IOM, DTR}), 32'b00);
    @(negedge CLK);
    chk("rd_t2", 32'({ALE, RD, WR, DEN}), 32'b0010);
    @(negedge CLK);
    chk("rd_t3", 32'({ALE, RD, WR, DEN}), 32'b0010);
    @(negedge CLK);
    chk("rd_t4", 32'({RD, WR, DEN}), 32'b111);
    drain();

    // I/O write
    issue(1'b1, 1'b1, 20'h0FF05, 8'h3C, 8'h00, 0, a1);
    @(negedge CLK);
    chk("io_t1", 32'({IOM, DTR, ALE}), 32'b111);
    chk("io_t1_a", 32'(A), 32'h0FF);
    @(negedge CLK);
    chk("io_t2", 32'({WR, RD, DEN}), 32'b010);
    chk("io_t2_ad", 32'(AD), 32'h3C);
    @(negedge CLK);
    chk("io_t3", 32'({WR, AD}), 32'h03C);
    drain();
    chk("io_store", 32'(io_mem[5]), 32'h3C);

    // I/O read with address bits above IO_AW masked off
    issue(1'b0, 1'b1, 20'h3FF0A, 8'h00, 8'h6B, 0, a1);
    @(negedge CLK);
    chk("io_mask_a", 32'(A), 32'h0FF);
    drain();

    // READY low for three sampling edges
    issue(1'b0, 1'b0, 20'h00040, 8'h00, 8'h5A, 3, a1);
    @(negedge CLK);
    @(negedge CLK);
    READY = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    @(negedge CLK);
    chk("tw_hold", 32'({RD, DEN, rsp_valid}), 32'b000);
    @(negedge CLK);
    READY = 1'b1;
    drain();

    // Back-to-back write then read
    issue(1'b1, 1'b0, 20'h90000, 8'h77, 8'h00, 0, a1);
    issue(1'b0, 1'b0, 20'h90000, 8'h00, 8'h77, 0, a2);
    chk("b2b_accept", a2 - a1, 32'd4);
    @(negedge CLK);
    chk("b2b_a", 32'(A), 32'h900);
    @(negedge CLK);
    chk("b2b_ale", ale_last - ale_prev, 32'd4);
    drain();

    // Reset during T2 of a write
    issue(1'b1, 1'b0, 20'h00100, 8'h99, 8'h00, 0, a1);
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_pre_wr", 32'(WR), 32'd0);
    sb.delete();
    RESET = 1'b1;
    #1;
    chk("rst_mid_strb", 32'({WR, DEN, RD, ALE}), 32'b1110);
    chk("rst_mid_ready", 32'(req_ready), 32'd0);
    probe = 1'b1;
    #1 chk("rst_mid_ad", 32'(AD), 32'h5C);
    probe = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_mid_rsp", 32'({rsp_valid, rsp_rdata}), 32'd0);
    RESET = 1'b0;
    last_rd = 8'h00;
    #1 chk("rel_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge CLK);

`ifdef BUS8088_HOLD_EN
    @(negedge CLK);
    HOLD      = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_io    = 1'b0;
    req_addr  = 20'h00012;
    #1 chk("hold_ready", 32'(req_ready), 32'd0);
    @(posedge CLK);
    #1 chk("hlda_on", 32'(HLDA), 32'd1);
    @(negedge CLK);
    chk("hold_bus", 32'({ALE, RD, WR, DEN}), 32'b0111);
    HOLD = 1'b0;
    @(posedge CLK);
    #1 chk("hlda_off", 32'(HLDA), 32'd0);
    issue(1'b0, 1'b0, 20'h00012, 8'h00, 8'hA5, 0, a1);
    drain();
`else
    HOLD = 1'b1;
    issue(1'b0, 1'b0, 20'h00012, 8'h00, 8'hA5, 0, a1);
    chk("hold_ignored", 32'(HLDA), 32'd0);
    HOLD = 1'b0;
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
